// File: rtl/sysid_arb_pkg.sv
// Shared types and constants for the sysid read arbiter.
package sysid_arb_pkg;

    localparam int MAX_N_REQ = 8;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        BOOT_ID,
        BOOT_WAIT,
        BOOT_TS,
        BOOT_CMP,
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // (base + off) mod n for base, off < n.
    function automatic int rr_wrap(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/sysid_arbiter_if.sv
// Requester-side Avalon-MM read bus, one lane per requester.
interface sysid_arbiter_if #(
    parameter int N_REQ = 2
) ();

    logic [N_REQ-1:0] req_read;
    logic [N_REQ-1:0] req_address;
    logic [N_REQ-1:0] req_waitrequest;
    logic [N_REQ-1:0] req_readdatavalid;
    logic [31:0]      req_readdata;

    // Requester view.
    modport master (
        output req_read,
        output req_address,
        input  req_waitrequest,
        input  req_readdatavalid,
        input  req_readdata
    );

    // Arbiter view.
    modport slave (
        input  req_read,
        input  req_address,
        output req_waitrequest,
        output req_readdatavalid,
        output req_readdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr.
module rr_arbiter
    import sysid_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [$clog2(N_REQ)-1:0] o_idx
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] w_j;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        w_j   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_j = IDX_W'(rr_wrap(int'(i_ptr), k, N_REQ));
            if (i_req[w_j]) begin
                o_gnt = N_REQ'(1) << w_j;
                o_idx = w_j;
            end
        end
    end

endmodule

// File: rtl/sysid_arbiter.sv
// Boot-checks the sysid slave, then shares it round-robin between requesters.
// One slave read in flight at a time; data captured READ_LATENCY cycles after
// the issue cycle. WAIT covers the extra latency cycles beyond the first and
// RESP is the capture cycle; with READ_LATENCY 0 the capture happens in ISSUE
// itself, with READ_LATENCY 1 WAIT is skipped.
module sysid_arbiter
    import sysid_arb_pkg::*;
#(
    parameter int          N_REQ              = 2,
    parameter int          READ_LATENCY       = 0,
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5154_8FB0
) (
    input  logic                clock,
    input  logic                reset_n,
    sysid_arbiter_if.slave      bus,
    output logic                address,
    output logic                read,
    input  logic [31:0]         readdata,
    output logic                boot_done,
    output logic                id_match,
    output logic [31:0]         sysid_id,
    output logic [31:0]         sysid_timestamp
);

    localparam int         IDX_W  = $clog2(N_REQ);
    localparam logic [1:0] LAT    = 2'(READ_LATENCY);
    localparam logic [1:0] LAT_P1 = 2'(READ_LATENCY + 1);
    localparam logic [1:0] LAT_M1 = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
    localparam logic       LAT0   = (READ_LATENCY == 0);

    state_t           r_state;
    state_t           w_nxt;
    logic             r_run;          // low for the first cycle after reset
    logic [1:0]       r_lat;          // cycles since the last issue
    logic [IDX_W-1:0] r_ptr;
    logic [N_REQ-1:0] r_gnt;
    logic             r_addr;
    logic             r_boot_done;
    logic             r_id_match;
    logic [31:0]      r_sysid_id;
    logic [31:0]      r_sysid_ts;
    logic [31:0]      r_rdata;
    logic [N_REQ-1:0] r_rdv;

    logic             w_read;
    logic             w_address;
    logic             w_issue;
    logic             w_cap;
    logic             w_any;
    logic [N_REQ-1:0] w_gnt;
    logic [IDX_W-1:0] w_idx;

    assign w_any = |bus.req_read;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .i_req (bus.req_read),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= BOOT_ID;
        else          r_state <= w_nxt;
    end

    // Next state, slave strobes and capture strobe.
    always_comb begin
        w_nxt     = r_state;
        w_read    = 1'b0;
        w_address = SYSID_ADDR_ID;
        w_issue   = 1'b0;
        w_cap     = 1'b0;
        case (r_state)
            BOOT_ID: begin
                if (r_run) begin
                    w_read  = 1'b1;
                    w_issue = 1'b1;
                    w_cap   = LAT0;
                    w_nxt   = BOOT_WAIT;
                end
            end
            BOOT_WAIT: begin
                w_cap = (r_lat == LAT);
                if (r_lat == LAT_P1) w_nxt = BOOT_TS;
            end
            BOOT_TS: begin
                w_read    = 1'b1;
                w_address = SYSID_ADDR_TS;
                w_issue   = 1'b1;
                w_cap     = LAT0;
                w_nxt     = BOOT_CMP;
            end
            BOOT_CMP: begin
                w_cap = (r_lat == LAT);
                if (r_lat == LAT_P1) w_nxt = IDLE;
            end
            IDLE: begin
                if (w_any) w_nxt = ISSUE;
            end
            ISSUE: begin
                w_read    = 1'b1;
                w_address = r_addr;
                w_issue   = 1'b1;
                w_cap     = LAT0;
                if (LAT0)                   w_nxt = IDLE;
                else if (READ_LATENCY == 1) w_nxt = RESP;
                else                        w_nxt = WAIT;
            end
            WAIT: begin
                if (r_lat == LAT_M1) w_nxt = RESP;
            end
            RESP: begin
                w_cap = 1'b1;
                w_nxt = IDLE;
            end
            default: w_nxt = BOOT_ID;
        endcase
    end

    // Latency counter, arbitration latch, data capture and boot compare.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_run       <= 1'b0;
            r_lat       <= '0;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_addr      <= 1'b0;
            r_boot_done <= 1'b0;
            r_id_match  <= 1'b0;
            r_sysid_id  <= '0;
            r_sysid_ts  <= '0;
            r_rdata     <= '0;
            r_rdv       <= '0;
        end else begin
            r_run <= 1'b1;
            r_rdv <= '0;

            if (w_issue)
                r_lat <= 2'd1;
            else if (r_state == BOOT_WAIT || r_state == BOOT_CMP || r_state == WAIT)
                r_lat <= r_lat + 2'd1;

            if (r_state == IDLE && w_any) begin
                r_gnt  <= w_gnt;
                r_addr <= |(w_gnt & bus.req_address);
                r_ptr  <= (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            end

            if (w_cap) begin
                case (r_state)
                    BOOT_ID, BOOT_WAIT: r_sysid_id <= readdata;
                    BOOT_TS, BOOT_CMP:  r_sysid_ts <= readdata;
                    default: begin
                        r_rdata <= readdata;
                        r_rdv   <= r_gnt;
                    end
                endcase
            end

            if (r_state == BOOT_CMP && r_lat == LAT_P1) begin
                r_boot_done <= 1'b1;
                r_id_match  <= (r_sysid_id == EXPECTED_ID) &&
                               (r_sysid_ts == EXPECTED_TIMESTAMP);
            end
        end
    end

    assign bus.req_waitrequest   = (r_state == ISSUE) ? ~r_gnt : '1;
    assign bus.req_readdatavalid = r_rdv;
    assign bus.req_readdata      = r_rdata;
    assign read                  = w_read;
    assign address               = w_address;
    assign boot_done             = r_boot_done;
    assign id_match              = r_id_match;
    assign sysid_id              = r_sysid_id;
    assign sysid_timestamp       = r_sysid_ts;

endmodule

// File: tb/tb_sysid_arbiter.sv
// Bench for sysid_arbiter: instance a (L=0, default expectations) and
// instance b (L=1, wrong expected timestamp), shared clock and reset.
module tb_sysid_arbiter;

    localparam logic [31:0] TS = 32'h5154_8FB0;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    int   rdv_cyc_a[$];
    exp_t e_a, e_b;

    logic        addr_a, rd_a, bd_a, im_a;
    logic [31:0] rdata_a, id_a, ts_a;
    logic        addr_b, rd_b, bd_b, im_b;
    logic [31:0] rdata_b, id_b, ts_b;
    logic [31:0] pipe_b = '0;
    logic        prev_rd_a = 1'b0, prev_rd_b = 1'b0;

    sysid_arbiter_if #(.N_REQ(2)) ifa ();
    sysid_arbiter_if #(.N_REQ(2)) ifb ();

    sysid_arbiter #(
        .N_REQ(2), .READ_LATENCY(0),
        .EXPECTED_ID(32'h0), .EXPECTED_TIMESTAMP(TS)
    ) dut_a (
        .clock(clk), .reset_n(rst_n), .bus(ifa),
        .address(addr_a), .read(rd_a), .readdata(rdata_a),
        .boot_done(bd_a), .id_match(im_a),
        .sysid_id(id_a), .sysid_timestamp(ts_a)
    );

    sysid_arbiter #(
        .N_REQ(2), .READ_LATENCY(1),
        .EXPECTED_ID(32'h0), .EXPECTED_TIMESTAMP(32'h1234_5678)
    ) dut_b (
        .clock(clk), .reset_n(rst_n), .bus(ifb),
        .address(addr_b), .read(rd_b), .readdata(rdata_b),
        .boot_done(bd_b), .id_match(im_b),
        .sysid_id(id_b), .sysid_timestamp(ts_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave models: latency 0 is combinational, latency 1 one register.
    assign rdata_a = addr_a ? TS : 32'h0;
    always @(posedge clk) pipe_b <= addr_b ? TS : 32'h0;
    assign rdata_b = pipe_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response scoreboards and back-to-back read guard.
    always @(negedge clk) begin
        chk("a_read_b2b", 32'(rd_a & prev_rd_a), 32'h0);
        chk("b_read_b2b", 32'(rd_b & prev_rd_b), 32'h0);
        prev_rd_a = rd_a;
        prev_rd_b = rd_b;
        if (ifa.req_readdatavalid != 2'b00) begin
            rdv_cyc_a.push_back(cyc);
            if (q_a.size() == 0) chk("a_unexp_rdv", 32'(ifa.req_readdatavalid), 32'h0);
            else begin
                e_a = q_a.pop_front();
                chk("a_rdv", 32'(ifa.req_readdatavalid), 32'(1) << e_a.idx);
                chk("a_data", ifa.req_readdata, e_a.data);
            end
        end
        if (ifb.req_readdatavalid != 2'b00) begin
            if (q_b.size() == 0) chk("b_unexp_rdv", 32'(ifb.req_readdatavalid), 32'h0);
            else begin
                e_b = q_b.pop_front();
                chk("b_rdv", 32'(ifb.req_readdatavalid), 32'(1) << e_b.idx);
                chk("b_data", ifb.req_readdata, e_b.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        ifa.req_read = 2'b00; ifa.req_address = 2'b00;
        ifb.req_read = 2'b00; ifb.req_address = 2'b00;
        repeat (3) @(negedge clk);

        // Reset state of both instances.
        chk("a_rst_wr",   32'(ifa.req_waitrequest), 32'h3);
        chk("a_rst_rdv",  32'(ifa.req_readdatavalid), 32'h0);
        chk("a_rst_read", 32'(rd_a), 32'h0);
        chk("a_rst_addr", 32'(addr_a), 32'h0);
        chk("a_rst_bd",   32'(bd_a), 32'h0);
        chk("a_rst_im",   32'(im_a), 32'h0);
        chk("a_rst_id",   id_a, 32'h0);
        chk("a_rst_ts",   ts_a, 32'h0);
        chk("a_rst_rd",   ifa.req_readdata, 32'h0);
        chk("b_rst_read", 32'(rd_b), 32'h0);
        chk("b_rst_bd",   32'(bd_b), 32'h0);
        rst_n = 1'b1;

        // Boot of both; requester 0 of a asks during boot.
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("a_read_k%0d", k), 32'(rd_a), 32'(k == 1 || k == 3 || k == 6));
            chk($sformatf("a_addr_k%0d", k), 32'(addr_a), 32'(k == 3));
            chk($sformatf("a_wr_k%0d", k), 32'(ifa.req_waitrequest), (k == 6) ? 32'h2 : 32'h3);
            chk($sformatf("a_bd_k%0d", k), 32'(bd_a), 32'(k >= 5));
            chk($sformatf("b_read_k%0d", k), 32'(rd_b), 32'(k == 1 || k == 4));
            chk($sformatf("b_addr_k%0d", k), 32'(addr_b), 32'(k == 4));
            chk($sformatf("b_bd_k%0d", k), 32'(bd_b), 32'(k >= 7));
            if (k == 1) begin
                ifa.req_read = 2'b01; ifa.req_address = 2'b00;
                q_a.push_back('{0, 32'h0});
            end
            if (k == 5) begin
                chk("a_boot_im", 32'(im_a), 32'h1);
                chk("a_boot_id", id_a, 32'h0);
                chk("a_boot_ts", ts_a, TS);
            end
            if (k == 6) ifa.req_read = 2'b00;
            if (k == 7) begin
                chk("b_boot_im", 32'(im_b), 32'h0);
                chk("b_boot_ts", ts_b, TS);
                chk("b_boot_id", id_b, 32'h0);
            end
        end

        // Single requester on b (L=1): requester 1, address 1.
        @(negedge clk);
        ifb.req_read = 2'b10; ifb.req_address = 2'b10;
        q_b.push_back('{1, TS});
        @(negedge clk);
        chk("b_wr_a1",   32'(ifb.req_waitrequest), 32'h1);
        chk("b_read_a1", 32'(rd_b), 32'h1);
        chk("b_addr_a1", 32'(addr_b), 32'h1);
        ifb.req_read = 2'b00;
        @(negedge clk);
        chk("b_wr_a2",  32'(ifb.req_waitrequest), 32'h3);
        chk("b_rdv_a2", 32'(ifb.req_readdatavalid), 32'h0);
        @(negedge clk);
        chk("b_rdv_a3",  32'(ifb.req_readdatavalid), 32'h2);
        chk("b_data_a3", ifb.req_readdata, TS);

        // Reset while b's read is in flight.
        @(negedge clk);
        ifb.req_read = 2'b01; ifb.req_address = 2'b01;
        @(negedge clk);
        ifb.req_read = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("b_mid_rdv",  32'(ifb.req_readdatavalid), 32'h0);
        chk("b_mid_wr",   32'(ifb.req_waitrequest), 32'h3);
        chk("b_mid_read", 32'(rd_b), 32'h0);
        chk("b_mid_addr", 32'(addr_b), 32'h0);
        chk("b_mid_bd",   32'(bd_b), 32'h0);
        chk("b_mid_im",   32'(im_b), 32'h0);
        chk("b_mid_id",   id_b, 32'h0);
        chk("b_mid_ts",   ts_b, 32'h0);
        chk("b_mid_rd",   ifb.req_readdata, 32'h0);
        chk("a_mid_bd",   32'(bd_a), 32'h0);
        @(negedge clk);
        chk("b_mid_rdv2", 32'(ifb.req_readdatavalid), 32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("b_rb_read_k%0d", k), 32'(rd_b), 32'(k == 1 || k == 4));
            chk($sformatf("b_rb_bd_k%0d", k), 32'(bd_b), 32'(k >= 7));
            chk($sformatf("a_rb_bd_k%0d", k), 32'(bd_a), 32'(k >= 5));
        end

        // Round-robin on a (L=0): both requesters hold for six grants.
        rdv_cyc_a.delete();
        for (int g = 0; g < 6; g++) q_a.push_back('{g % 2, (g % 2 == 1) ? TS : 32'h0});
        ifa.req_address = 2'b10;
        ifa.req_read    = 2'b11;
        repeat (11) @(negedge clk);
        ifa.req_read = 2'b00;

        for (int t = 0; t < 40 && (q_a.size() != 0 || q_b.size() != 0); t++) @(negedge clk);
        chk("a_drain", 32'(q_a.size()), 32'h0);
        chk("b_drain", 32'(q_b.size()), 32'h0);
        chk("rr_count", 32'(rdv_cyc_a.size()), 32'd6);
        for (int i = 1; i < rdv_cyc_a.size(); i++)
            chk($sformatf("rr_gap%0d", i), 32'(rdv_cyc_a[i] - rdv_cyc_a[i-1]), 32'd2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
